// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and unified-memory handshake signals seen by the arbiter.
// slave is the arbiter's view; master is the surrounding pipeline/memory view.
interface mem_port_arbiter_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;

  logic          dm_rd;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          dm_stall;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;

  logic          err;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_done, if_stall,
    input  dm_rd, dm_wr, dm_addr, dm_wdata,
    output dm_rdata, dm_done, dm_stall,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_done,
    output err
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_done, if_stall,
    output dm_rd, dm_wr, dm_addr, dm_wdata,
    input  dm_rdata, dm_done, dm_stall,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_done,
    input  err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and the memory stage.
// Data accesses win ties; flushed fetches are drained silently; timeouts and illegal requests set a sticky err.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 64
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DW    = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DM_BUSY    = 2'd1,
    IF_BUSY    = 2'd2,
    IF_DISCARD = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             err_q;
  logic             err_next;
  logic             dm_req;
  logic             dm_bad;
  logic             expired;

  assign dm_req  = bus.dm_rd ^ bus.dm_wr;
  assign dm_bad  = bus.dm_rd & bus.dm_wr;
  // Last busy cycle allowed without mem_done before the access is abandoned.
  assign expired = (wait_cnt == CNT_W'(MAX_WAIT - 1));
  assign bus.err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      err_q    <= err_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    err_next      = err_q;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_done   = 1'b0;
    bus.if_rdata  = '0;
    bus.dm_done   = 1'b0;
    bus.dm_rdata  = '0;
    bus.if_stall  = 1'b0;
    bus.dm_stall  = 1'b0;

    unique case (state)
      IDLE: begin
        // Late or stale mem_done is ignored here; counter is primed for the next busy state.
        wait_cnt_next = '0;
        if (dm_bad) begin
          err_next = 1'b1;
        end else if (dm_req) begin
          bus.mem_rd    = bus.dm_rd;
          bus.mem_wr    = bus.dm_wr;
          bus.mem_addr  = bus.dm_addr;
          bus.mem_wdata = bus.dm_wdata;
          state_next    = DM_BUSY;
        end else if (bus.if_req && !bus.if_flush) begin
          bus.mem_rd   = 1'b1;
          bus.mem_addr = bus.if_addr;
          state_next   = IF_BUSY;
        end
      end

      DM_BUSY: begin
        if (bus.mem_done) begin
          bus.dm_done  = 1'b1;
          bus.dm_rdata = bus.mem_rdata;
          state_next   = IDLE;
        end else if (expired) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end

      IF_BUSY: begin
        if (bus.mem_done) begin
          if (!bus.if_flush) begin
            bus.if_done  = 1'b1;
            bus.if_rdata = bus.mem_rdata;
          end
          state_next = IDLE;
        end else if (expired) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
          if (bus.if_flush) begin
            state_next = IF_DISCARD;
          end
        end
      end

      IF_DISCARD: begin
        // The cancelled fetch still owns the port until its response drains.
        if (bus.mem_done) begin
          state_next = IDLE;
        end else if (expired) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    bus.dm_stall = (bus.dm_rd | bus.dm_wr) & ~bus.dm_done;
    bus.if_stall = bus.if_req & ~bus.if_done & ~bus.if_flush;

    // Hold every combinational output quiet while reset is asserted.
    if (rst) begin
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.if_done   = 1'b0;
      bus.if_rdata  = DW'(0);
      bus.dm_done   = 1'b0;
      bus.dm_rdata  = DW'(0);
      bus.if_stall  = 1'b0;
      bus.dm_stall  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (MAX_WAIT=4); each row is one clock cycle.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_flush;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
  } in_t;

  typedef struct packed {
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        if_stall;
    logic        dm_done;
    logic [15:0] dm_rdata;
    logic        dm_stall;
    logic        err;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  vec_t tbl[$];

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t fi(input logic r, input logic ireq, input logic [15:0] iaddr, input logic ifl,
                             input logic drd, input logic dwr, input logic [15:0] daddr,
                             input logic [15:0] dwdata, input logic [15:0] mrdata, input logic mdone);
    in_t v;
    v.rst = r; v.if_req = ireq; v.if_addr = iaddr; v.if_flush = ifl;
    v.dm_rd = drd; v.dm_wr = dwr; v.dm_addr = daddr; v.dm_wdata = dwdata;
    v.mem_rdata = mrdata; v.mem_done = mdone;
    return v;
  endfunction

  function automatic out_t fo(input logic mrd, input logic mwr, input logic [15:0] maddr,
                              input logic [15:0] mwdata, input logic idone, input logic [15:0] irdata,
                              input logic istall, input logic ddone, input logic [15:0] drdata,
                              input logic dstall, input logic e);
    out_t v;
    v.mem_rd = mrd; v.mem_wr = mwr; v.mem_addr = maddr; v.mem_wdata = mwdata;
    v.if_done = idone; v.if_rdata = irdata; v.if_stall = istall;
    v.dm_done = ddone; v.dm_rdata = drdata; v.dm_stall = dstall; v.err = e;
    return v;
  endfunction

  task automatic add(input string name, input in_t i, input out_t o);
    vec_t v;
    v.name = name; v.i = i; v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t i);
    rst           = i.rst;
    bus.if_req    = i.if_req;
    bus.if_addr   = i.if_addr;
    bus.if_flush  = i.if_flush;
    bus.dm_rd     = i.dm_rd;
    bus.dm_wr     = i.dm_wr;
    bus.dm_addr   = i.dm_addr;
    bus.dm_wdata  = i.dm_wdata;
    bus.mem_rdata = i.mem_rdata;
    bus.mem_done  = i.mem_done;
  endtask

  // Apply inputs just after the edge, compare well before the next one.
  task automatic step(input string name, input in_t i, input out_t o);
    out_t act;
    @(posedge clk);
    #1;
    drive(i);
    #3;
    act = {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.if_done, bus.if_rdata,
           bus.if_stall, bus.dm_done, bus.dm_rdata, bus.dm_stall, bus.err};
    n_cmp++;
    if (act !== o) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, o);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive(fi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    add("reset_outputs",   fi(1,0,16'h0000,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,0));
    add("if_issue",        fi(0,1,16'h0040,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(1,0,16'h0040,16'h0000,0,16'h0000,1,0,16'h0000,0,0));
    add("if_wait1",        fi(0,1,16'h0040,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,1,0,16'h0000,0,0));
    add("if_wait2",        fi(0,1,16'h0040,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,1,0,16'h0000,0,0));
    add("if_done",         fi(0,1,16'h0040,0,0,0,16'h0000,16'h0000,16'hA5A5,1), fo(0,0,16'h0000,16'h0000,1,16'hA5A5,0,0,16'h0000,0,0));
    add("idle_late_done",  fi(0,0,16'h0000,0,0,0,16'h0000,16'h0000,16'hFFFF,1), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,0));
    add("conf_wr_issue",   fi(0,1,16'h0042,0,0,1,16'h1000,16'h1234,16'h0000,0), fo(0,1,16'h1000,16'h1234,0,16'h0000,1,0,16'h0000,1,0));
    add("conf_wr_wait",    fi(0,1,16'h0042,0,0,1,16'h1000,16'h1234,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,1,0,16'h0000,1,0));
    add("conf_dm_done",    fi(0,1,16'h0042,0,0,1,16'h1000,16'h1234,16'hBEEF,1), fo(0,0,16'h0000,16'h0000,0,16'h0000,1,1,16'hBEEF,0,0));
    add("conf_if_issue",   fi(0,1,16'h0042,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(1,0,16'h0042,16'h0000,0,16'h0000,1,0,16'h0000,0,0));
    add("conf_if_done",    fi(0,1,16'h0042,0,0,0,16'h0000,16'h0000,16'h1111,1), fo(0,0,16'h0000,16'h0000,1,16'h1111,0,0,16'h0000,0,0));
    add("rd_issue",        fi(0,0,16'h0000,0,1,0,16'h2000,16'h0000,16'h0000,0), fo(1,0,16'h2000,16'h0000,0,16'h0000,0,0,16'h0000,1,0));
    add("rd_done",         fi(0,0,16'h0000,0,1,0,16'h2000,16'h0000,16'h5A5A,1), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,1,16'h5A5A,0,0));
    add("fl_issue",        fi(0,1,16'h0044,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(1,0,16'h0044,16'h0000,0,16'h0000,1,0,16'h0000,0,0));
    add("fl_flush",        fi(0,1,16'h0044,1,0,0,16'h0000,16'h0000,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,0));
    add("fl_discard",      fi(0,1,16'h0080,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,1,0,16'h0000,0,0));
    add("fl_drop",         fi(0,1,16'h0080,0,0,0,16'h0000,16'h0000,16'hDEAD,1), fo(0,0,16'h0000,16'h0000,0,16'h0000,1,0,16'h0000,0,0));
    add("fl_refetch",      fi(0,1,16'h0080,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(1,0,16'h0080,16'h0000,0,16'h0000,1,0,16'h0000,0,0));
    add("fl_refetch_done", fi(0,1,16'h0080,0,0,0,16'h0000,16'h0000,16'h0F0F,1), fo(0,0,16'h0000,16'h0000,1,16'h0F0F,0,0,16'h0000,0,0));
    add("fd_issue",        fi(0,1,16'h0090,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(1,0,16'h0090,16'h0000,0,16'h0000,1,0,16'h0000,0,0));
    add("fd_flush_done",   fi(0,1,16'h0090,1,0,0,16'h0000,16'h0000,16'h7777,1), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,0));
    add("fd_next_issue",   fi(0,1,16'h00A0,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(1,0,16'h00A0,16'h0000,0,16'h0000,1,0,16'h0000,0,0));
    add("fd_next_done",    fi(0,1,16'h00A0,0,0,0,16'h0000,16'h0000,16'h2222,1), fo(0,0,16'h0000,16'h0000,1,16'h2222,0,0,16'h0000,0,0));
    add("idle_flush",      fi(0,1,16'h00B0,1,0,0,16'h0000,16'h0000,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,0));
    add("idle_quiet",      fi(0,0,16'h0000,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,0));
    add("illegal_rdwr",    fi(0,0,16'h0000,0,1,1,16'h3000,16'h5555,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,1,0));
    add("illegal_err",     fi(0,0,16'h0000,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,1));
    add("err_sticky",      fi(0,0,16'h0000,0,0,0,16'h0000,16'h0000,16'h6666,1), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,1));
    add("err_in_rst",      fi(1,0,16'h0000,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,1));
    add("err_cleared",     fi(0,0,16'h0000,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,0));

    @(posedge clk);
    foreach (tbl[k]) step(tbl[k].name, tbl[k].i, tbl[k].o);

    // Timeout: read never completes; abort after 4 busy cycles, port reusable, err sticky.
    step("to_issue", fi(0,0,16'h0000,0,1,0,16'h3000,16'h0000,16'h0000,0), fo(1,0,16'h3000,16'h0000,0,16'h0000,0,0,16'h0000,1,0));
    for (int k = 1; k <= 4; k++)
      step("to_busy", fi(0,0,16'h0000,0,1,0,16'h3000,16'h0000,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,1,0));
    step("to_idle_fetch", fi(0,1,16'h00B0,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(1,0,16'h00B0,16'h0000,0,16'h0000,1,0,16'h0000,0,1));
    step("to_fetch_done", fi(0,1,16'h00B0,0,0,0,16'h0000,16'h0000,16'h3333,1), fo(0,0,16'h0000,16'h0000,1,16'h3333,0,0,16'h0000,0,1));

    // Reset during DM_BUSY, then a stale mem_done must be ignored.
    step("rm_issue",     fi(0,0,16'h0000,0,1,0,16'h4000,16'h0000,16'h0000,0), fo(1,0,16'h4000,16'h0000,0,16'h0000,0,0,16'h0000,1,1));
    step("rm_rst",       fi(1,0,16'h0000,0,1,0,16'h4000,16'h0000,16'h0000,0), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,1));
    step("rm_late_done", fi(0,0,16'h0000,0,0,0,16'h0000,16'h0000,16'h9999,1), fo(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,0));
    step("rm_fetch",     fi(0,1,16'h00C0,0,0,0,16'h0000,16'h0000,16'h0000,0), fo(1,0,16'h00C0,16'h0000,0,16'h0000,1,0,16'h0000,0,0));
    step("rm_fetch_done",fi(0,1,16'h00C0,0,0,0,16'h0000,16'h0000,16'h4444,1), fo(0,0,16'h0000,16'h0000,1,16'h4444,0,0,16'h0000,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared, variable-latency unified memory port between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the 5-stage pipeline.
- Sequences each transaction through a request/done handshake and returns data to the requester that issued it.
- Generates per-stage stall signals, discards fetches cancelled by a branch flush, and flags protocol errors and memory timeouts.

Parameters:
- MAX_WAIT, 64, busy cycles allowed before a transaction is aborted as a timeout (1..255).

Ports:
- clk  input  1  system clock, single clock domain
- rst  input  1  synchronous active-high reset
- if_req  input  1  fetch requests an instruction read; held until if_done
- if_addr  input  16  fetch address
- if_flush  input  1  branch/jump flush; cancels the current or pending fetch
- if_rdata  output  16  instruction data, valid when if_done=1
- if_done  output  1  fetch complete, one-cycle pulse
- if_stall  output  1  fetch must hold
- dm_rd  input  1  memory stage read request; held until dm_done
- dm_wr  input  1  memory stage write request; held until dm_done
- dm_addr  input  16  data address
- dm_wdata  input  16  write data
- dm_rdata  output  16  load data, valid when dm_done=1
- dm_done  output  1  data access complete, one-cycle pulse
- dm_stall  output  1  memory stage must hold
- mem_rd  output  1  port read strobe, one-cycle pulse
- mem_wr  output  1  port write strobe, one-cycle pulse
- mem_addr  output  16  port address, valid with a strobe
- mem_wdata  output  16  port write data, valid with mem_wr
- mem_rdata  input  16  port read data, valid with mem_done
- mem_done  input  1  port completion, at least 1 cycle after the strobe
- err  output  1  sticky error flag

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. State=IDLE, wait counter=0, err=0.
- Reset values of outputs: all strobes, dones and stalls are 0; data outputs are 0.
- States: IDLE, DM_BUSY, IF_BUSY, IF_DISCARD.
- IDLE, data request present (dm_rd^dm_wr):
  - Strobes are combinational in the same cycle: mem_rd=dm_rd, mem_wr=dm_wr, mem_addr=dm_addr, mem_wdata=dm_wdata.
  - Next state DM_BUSY.
  - Data has priority over fetch because the memory-stage instruction is older.
- IDLE, no data request, if_req=1 and if_flush=0:
  - mem_rd=1, mem_addr=if_addr.
  - Next state IF_BUSY.
- IDLE, if_flush=1: no fetch is issued that cycle.
- IDLE, dm_rd&dm_wr both 1: illegal. No strobe is issued and err is set.
- DM_BUSY, mem_done=1:
  - dm_done=1 and dm_rdata=mem_rdata, combinational.
  - Next state IDLE. A new request is issued no earlier than the following cycle.
- IF_BUSY, mem_done=1 and if_flush=0: if_done=1, if_rdata=mem_rdata, next state IDLE.
- IF_BUSY, if_flush=1 (with or without mem_done):
  - if_done is suppressed.
  - With mem_done, next state IDLE; without it, next state IF_DISCARD.
- IF_DISCARD, mem_done=1: data is dropped, next state IDLE. No done is generated.
- Stalls:
  - dm_stall = (dm_rd|dm_wr) & ~dm_done.
  - if_stall = if_req & ~if_done, forced to 0 when if_flush=1.
- Wait counter:
  - Cleared on entering any busy state; increments each busy cycle without mem_done.
  - At count MAX_WAIT: err is set, the state is forced to IDLE and no done is generated.
- mem_done in IDLE (a late response or one from before reset) is ignored. It must not generate a done.
- A simultaneous data and fetch request in IDLE issues data first. The fetch stalls until at least 1 cycle after dm_done.
- Minimum transaction: strobe cycle plus a done cycle, i.e. 2 cycles request-to-done.
- err is cleared only by rst.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0040, memory done after 3 cycles with rdata=0xA5A5 -> mem_rd pulses once with addr 0x0040; if_stall=1 for 3 cycles; if_done=1 with if_rdata=0xA5A5.
- Conflict: dm_wr=1 (addr 0x1000, wdata 0x1234) and if_req=1 (0x0042) in the same IDLE cycle -> write strobe first; dm_done after its mem_done; fetch strobe no earlier than the cycle after dm_done; if_stall high throughout.
- Flush mid-fetch: fetch issued, if_flush=1 on busy cycle 1, mem_done on cycle 3 -> if_done never asserts; state IDLE after mem_done; next fetch issues normally.
- Flush coincident with mem_done -> no if_done; state IDLE the next cycle.
- Timeout: MAX_WAIT=4, dm_rd issued, mem_done never comes -> err=1 after 4 busy cycles; state IDLE; dm_done never pulses; err holds until rst.
- Reset mid-transaction: rst during DM_BUSY, then a late mem_done in IDLE -> all outputs 0; no done pulse; err=0.
